// File: rtl/seq_detector_param_if.sv
// Serial bit stream, pattern reload and match outputs of seq_detector_param.
// match_count is present only when SEQ_DETECTOR_MATCH_CNT_EN is defined.
interface seq_detector_param_if #(
  parameter int PATTERN_W = 4,
  parameter int CNT_W     = 8
);
  logic                 data_in;
  logic                 data_valid;
  logic                 overlap;
  logic                 pat_load;
  logic [PATTERN_W-1:0] pat_in;
  logic                 data_out;
  logic                 busy;
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
  logic [CNT_W-1:0]     match_count;
`endif

  if (CNT_W < 1) begin : g_bad_cnt
    $error("seq_detector_param_if: CNT_W must be >= 1");
  end

  modport master (
    output data_in, data_valid, overlap,
    output pat_load, pat_in,
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    input  match_count,
`endif
    input  data_out, busy
  );

  modport slave (
    input  data_in, data_valid, overlap,
    input  pat_load, pat_in,
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
    output match_count,
`endif
    output data_out, busy
  );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector, run-time pattern reload and overlap.
// Define SEQ_DETECTOR_MATCH_CNT_EN to add the saturating match_count output.
module seq_detector_param #(
  parameter int                   PATTERN_W   = 4,
  parameter logic [PATTERN_W-1:0] PATTERN_DEF = PATTERN_W'(4'b1101),
  parameter int                   CNT_W       = 8
) (
  input logic                 clk,
  input logic                 reset,
  seq_detector_param_if.slave bus
);
  localparam int FW = $clog2(PATTERN_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PATTERN_W);

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    ARMED
  } state_t;

  state_t               state;
  logic [PATTERN_W-1:0] hist;
  logic [PATTERN_W-1:0] pat;
  logic [PATTERN_W-1:0] nxt_hist;
  logic [FW-1:0]        fill;
  logic [FW-1:0]        nxt_fill;
  logic                 hit;
  logic                 out_q;
  logic                 busy_q;

  if (PATTERN_W < 2 || PATTERN_W > 32) begin : g_bad_w
    $error("seq_detector_param: PATTERN_W must be 2..32");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("seq_detector_param: CNT_W must be >= 1");
  end

  // Oldest bit falls off the MSB as the new bit enters at the LSB.
  always_comb begin
    nxt_hist = (hist << 1) | PATTERN_W'(bus.data_in);
    nxt_fill = (state == ARMED) ? FULL : fill + FW'(1);
    hit      = (nxt_fill == FULL) && (nxt_hist == pat);
  end

`ifdef SEQ_DETECTOR_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;
  assign bus.match_count = cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      hist   <= '0;
      fill   <= '0;
      pat    <= PATTERN_DEF;
      out_q  <= 1'b0;
      busy_q <= 1'b0;
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
      cnt    <= '0;
`endif
    end else if (bus.pat_load) begin
      state  <= EMPTY;
      hist   <= '0;
      fill   <= '0;
      pat    <= bus.pat_in;
      out_q  <= 1'b0;
      busy_q <= 1'b0;
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
      cnt    <= '0;
`endif
    end else if (bus.data_valid) begin
      out_q <= hit;
      if (hit && !bus.overlap) begin
        state  <= EMPTY;
        hist   <= '0;
        fill   <= '0;
        busy_q <= 1'b0;
      end else begin
        state  <= (nxt_fill == FULL) ? ARMED : FILLING;
        hist   <= nxt_hist;
        fill   <= nxt_fill;
        busy_q <= 1'b1;
      end
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
      if (hit && cnt != '1)
        cnt <= cnt + CNT_W'(1);
`endif
    end else begin
      out_q <= 1'b0;
    end
  end

  assign bus.data_out = out_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: directed streams, queued
// expectations, and a monitor that checks each cycle's registered outputs.
module tb_seq_detector_param;
  logic clk;
  logic reset;

  seq_detector_param_if #(.PATTERN_W(4), .CNT_W(2)) bus();

  seq_detector_param #(
    .PATTERN_W  (4),
    .PATTERN_DEF(4'b1101),
    .CNT_W      (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic  o;
    logic  b;
    int    c;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: one expectation per clock, sampled 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (bus.data_out !== e.o) begin
        errors++;
        $display("FAIL %s data_out got %b want %b",
                 e.nm, bus.data_out, e.o);
      end
      checks++;
      if (bus.busy !== e.b) begin
        errors++;
        $display("FAIL %s busy got %b want %b",
                 e.nm, bus.busy, e.b);
      end
`ifdef SEQ_DETECTOR_MATCH_CNT_EN
      if (e.c >= 0) begin
        checks++;
        if (bus.match_count !== 2'(e.c)) begin
          errors++;
          $display("FAIL %s match_count got %0d want %0d",
                   e.nm, bus.match_count, e.c);
        end
      end
`endif
    end
  end

  task automatic cyc(input logic v, input logic d,
                     input logic ld, input logic [3:0] p,
                     input logic ov, input logic eo,
                     input logic eb, input int ec,
                     input string nm);
    exp_t e;
    @(negedge clk);
    reset          = 1'b0;
    bus.data_valid = v;
    bus.data_in    = d;
    bus.pat_load   = ld;
    bus.pat_in     = p;
    bus.overlap    = ov;
    e.o  = eo;
    e.b  = eb;
    e.c  = ec;
    e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic bit_in(input logic d, input logic ov,
                        input logic eo, input logic eb,
                        input int ec, input string nm);
    cyc(1'b1, d, 1'b0, 4'h0, ov, eo, eb, ec, nm);
  endtask

  task automatic do_reset(input string nm);
    exp_t e;
    @(negedge clk);
    reset          = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in    = 1'b1;
    bus.pat_load   = 1'b0;
    bus.pat_in     = 4'h0;
    bus.overlap    = 1'b1;
    e.o  = 1'b0;
    e.b  = 1'b0;
    e.c  = 0;
    e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin
    reset          = 1'b1;
    bus.data_in    = 1'b0;
    bus.data_valid = 1'b0;
    bus.overlap    = 1'b0;
    bus.pat_load   = 1'b0;
    bus.pat_in     = 4'h0;

    do_reset("rst0");

    // T1: 1101101, overlap on -> matches after bits 4 and 7
    bit_in(1, 1, 0, 1, 0, "t1b1");
    bit_in(1, 1, 0, 1, 0, "t1b2");
    bit_in(0, 1, 0, 1, 0, "t1b3");
    bit_in(1, 1, 1, 1, 1, "t1b4");
    bit_in(1, 1, 0, 1, 1, "t1b5");
    bit_in(0, 1, 0, 1, 1, "t1b6");
    bit_in(1, 1, 1, 1, 2, "t1b7");

    // T2: same stream, overlap off -> only first match
    do_reset("rst2");
    bit_in(1, 0, 0, 1, 0, "t2b1");
    bit_in(1, 0, 0, 1, 0, "t2b2");
    bit_in(0, 0, 0, 1, 0, "t2b3");
    bit_in(1, 0, 1, 0, 1, "t2b4");
    bit_in(1, 0, 0, 1, 1, "t2b5");
    bit_in(0, 0, 0, 1, 1, "t2b6");
    bit_in(1, 0, 0, 1, 1, "t2b7");

    // T3: valid gap of 3 cycles between bits 2 and 3
    do_reset("rst3");
    bit_in(1, 1, 0, 1, 0, "t3b1");
    bit_in(1, 1, 0, 1, 0, "t3b2");
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 0, 4'h0, 1, 0, 1, 0, "t3gap");
    bit_in(0, 1, 0, 1, 0, "t3b3");
    bit_in(1, 1, 1, 1, 1, "t3b4");
    cyc(0, 1, 0, 4'h0, 1, 0, 1, 1, "t3idle");

    // T4: load 0110 with valid high -> bit discarded
    do_reset("rst4");
    bit_in(1, 1, 0, 1, 0, "t4pre1");
    bit_in(1, 1, 0, 1, 0, "t4pre2");
    cyc(1, 1, 1, 4'b0110, 1, 0, 0, 0, "t4load");
    bit_in(0, 1, 0, 1, 0, "t4b1");
    bit_in(1, 1, 0, 1, 0, "t4b2");
    bit_in(1, 1, 0, 1, 0, "t4b3");
    bit_in(0, 1, 1, 1, 1, "t4b4");

    // T5: mid-stream reset restores default pattern
    do_reset("rst5");
    bit_in(1, 1, 0, 1, 0, "t5b1");
    bit_in(1, 1, 0, 1, 0, "t5b2");
    bit_in(0, 1, 0, 1, 0, "t5b3");
    do_reset("t5rst");
    bit_in(1, 1, 0, 1, 0, "t5x");
    bit_in(1, 1, 0, 1, 0, "t5c1");
    bit_in(1, 1, 0, 1, 0, "t5c2");
    bit_in(0, 1, 0, 1, 0, "t5c3");
    bit_in(1, 1, 1, 1, 1, "t5c4");

    // T6: pattern 1111, eight ones, overlap on -> 5 pulses
    do_reset("rst6");
    cyc(0, 0, 1, 4'b1111, 1, 0, 0, 0, "t6load");
    bit_in(1, 1, 0, 1, 0, "t6b1");
    bit_in(1, 1, 0, 1, 0, "t6b2");
    bit_in(1, 1, 0, 1, 0, "t6b3");
    bit_in(1, 1, 1, 1, 1, "t6b4");
    bit_in(1, 1, 1, 1, 2, "t6b5");
    bit_in(1, 1, 1, 1, 3, "t6b6");
    bit_in(1, 1, 1, 1, 3, "t6b7");
    bit_in(1, 1, 1, 1, 3, "t6b8");
    cyc(0, 0, 0, 4'h0, 1, 0, 1, 3, "t6idle");

    for (int i = 0; i < 20 && sb.size() > 0; i++)
      @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised serial pattern detector; successor to the fixed 4-bit "1101" detector FSM.
- Pattern width and reset-default pattern are parameters. Pattern is reloadable at run time.
- Input bits are qualified by a valid strobe. Overlapping or non-overlapping detection is selected at run time.
- Sits on a serial bit stream (e.g. deserialiser output). Gives a registered one-cycle match pulse to downstream framing logic.

Parameters:
- PATTERN_W, 4, pattern length in bits (2..32).
- PATTERN_DEF, 4'b1101 (PATTERN_W bits), pattern value after reset. Bit PATTERN_W-1 is the first bit received.
- CNT_W, 8, width of the match counter (used only with MATCH_CNT_EN).

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  1  serial data bit.
- data_valid  in  1  data_in is sampled only when high.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- pat_load  in  1  load pat_in as the new pattern.
- pat_in  in  PATTERN_W  new pattern value.
- data_out  out  1  registered match pulse, high for one cycle per match.
- busy  out  1  high when fill > 0 (partial or full history held).
- match_count  out  CNT_W  saturating match count; port exists only with MATCH_CNT_EN.

Behaviour:
- Internal registers:
  - hist[PATTERN_W-1:0] shift register; new bit enters at LSB; the oldest bit is the MSB.
  - fill counter, 0..PATTERN_W.
  - pat register.
- Reset (synchronous, any cycle, including mid-stream): hist=0, fill=0, pat=PATTERN_DEF, data_out=0, busy=0, match_count=0.
- FSM state is derived from fill:
  - EMPTY (fill=0).
  - FILLING (0<fill<PATTERN_W).
  - ARMED (fill=PATTERN_W).
- Accepted bit (data_valid=1, pat_load=0):
  - hist <= {hist[PATTERN_W-2:0], data_in}.
  - fill increments and saturates at PATTERN_W.
  - Transitions: EMPTY->FILLING; FILLING->ARMED when fill reaches PATTERN_W; ARMED stays ARMED.
- Match condition: the new fill equals PATTERN_W and the new hist equals pat.
  - data_out is registered high in the cycle after the final pattern bit is presented (latency 1 clock).
- After a match:
  - overlap=1: fill stays PATTERN_W; the next bit can complete another match.
  - overlap=0: fill <= 0 and hist <= 0; next state EMPTY; PATTERN_W fresh bits are needed before the next match.
- overlap is sampled on the cycle of the matching bit. Changing it mid-stream is legal and applies from that cycle.
- data_valid=0: hist, fill and state hold; data_out <= 0.
- pat_load=1: pat <= pat_in, hist <= 0, fill <= 0, data_out <= 0.
  - If data_valid is also high in that cycle, load wins and the bit is discarded.
- data_out is never high for two consecutive cycles unless valid bits arrive back to back and both complete matches (possible only with overlap=1, e.g. pattern all-ones).
- busy = (fill != 0), registered consistently with fill.
- PATTERN_W=2 is the minimum width. Widths outside 2..32 are unsupported; a simulation-only check flags them at elaboration.

Optional Feature:
- Macro: SEQ_DETECTOR_MATCH_CNT_EN.
- Defined:
  - match_count port exists.
  - It increments by 1 in the same cycle data_out is set, and saturates at 2^CNT_W-1 (no wrap).
  - It is cleared by reset and by pat_load.
- Undefined: no match_count port and no counter logic. All other behaviour is identical.

Test Plan:
- 1. PATTERN_W=4, default pattern 1101, overlap=1, stream 1,1,0,1,1,0,1 with valid every cycle -> data_out pulses 1 cycle after bit 4 and after bit 7; match_count=2.
- 2. Same stream, overlap=0 -> data_out pulses only after bit 4; fill=3 at end; busy=1; match_count=1.
- 3. Stream 1,1,0,1 with data_valid low for 3 cycles between bits 2 and 3 -> single match after bit 4; data_out stays 0 during the gap cycles.
- 4. pat_load with pat_in=4'b0110 while data_valid=1 -> incoming bit discarded, fill=0, busy=0; then stream 0,1,1,0 -> one match.
- 5. Reset asserted after bits 1,1,0 -> fill=0; following bit 1 gives no match; a full 1,1,0,1 gives a match.
- 6. With SEQ_DETECTOR_MATCH_CNT_EN, CNT_W=2, overlap=1, pattern 1111, 8 consecutive 1s -> 5 matches; match_count saturates at 3.
